// File: rtl/mul_seq_unit.sv
// mul_seq_unit
// Iterative shift-add multiplier serving MUL and MLA instructions.
// Operands come straight from the register file read ports. One
// multiplier bit is consumed per RUN cycle. The finished value is offered
// as a single-cycle write-back request, and the PC is held while an
// operation is in flight.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, overrides every other input
//   start        multiply request, only honoured while idle
//   accumulate   1 = MLA (Rm*Rs+Rn), 0 = MUL (Rm*Rs), captured with start
//   set_flags    S bit, captured with start
//   Rm, Rs, Rn   multiplicand, multiplier and accumulate operand
//   rd_addr_in   destination register, captured with start
//   busy         unit is not idle
//   stall_pc     hold the PC (accepted start cycle and every RUN cycle)
//   done         one-cycle pulse, result valid
//   write_en     register-file write enable, identical to done
//   rd_addr_out  captured destination, held until the next accepted start
//   result       low 32 bits of the product or sum, held after done
//   flag_valid   done qualified by the captured S bit
//   flag_n       sign of result, meaningful with flag_valid
//   flag_z       result is zero, meaningful with flag_valid

module mul_seq_unit #(
    parameter int unsigned EARLY_TERM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        accumulate,
    input  logic        set_flags,
    input  logic [31:0] Rm,
    input  logic [31:0] Rs,
    input  logic [31:0] Rn,
    input  logic [3:0]  rd_addr_in,
    output logic        busy,
    output logic        stall_pc,
    output logic        done,
    output logic        write_en,
    output logic [3:0]  rd_addr_out,
    output logic [31:0] result,
    output logic        flag_valid,
    output logic        flag_n,
    output logic        flag_z
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q,    acc_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  count_q,  count_d;
    logic [3:0]  rd_q,     rd_d;
    logic        setf_q,   setf_d;
    logic        flag_n_q, flag_n_d;
    logic        flag_z_q, flag_z_d;

    logic        early;
    logic [31:0] acc_step;
    logic        last_iter;
    logic        load_result;
    logic [31:0] result_new;
    logic [31:0] acc_init;

    assign early    = (EARLY_TERM != 0);
    assign acc_init = accumulate ? Rn : 32'd0;

    // Accumulator value after this RUN cycle's conditional add.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // This RUN cycle is the final one when either the full 32 iterations
    // are used up, or (with early termination) no set multiplier bits
    // remain once the current bit has been consumed.
    assign last_iter = (count_q == 5'd31) ||
                       (early && (mplier_q[31:1] == 31'd0));

    // Next-state and datapath logic. The result and the flags are only
    // loaded on entry to DONE, so they stay put between operations.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;
        rd_d        = rd_q;
        setf_d      = setf_q;
        result_d    = result_q;
        flag_n_d    = flag_n_q;
        flag_z_d    = flag_z_q;
        load_result = 1'b0;
        result_new  = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = Rm;
                    mplier_d = Rs;
                    acc_d    = acc_init;
                    rd_d     = rd_addr_in;
                    setf_d   = set_flags;
                    count_d  = 5'd0;
                    // A zero multiplier leaves only the accumulator.
                    if (early && (Rs == 32'd0)) begin
                        state_d     = ST_DONE;
                        load_result = 1'b1;
                        result_new  = acc_init;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (last_iter) begin
                    state_d     = ST_DONE;
                    load_result = 1'b1;
                    result_new  = acc_step;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_result) begin
            result_d = result_new;
            flag_n_d = result_new[31];
            flag_z_d = (result_new == 32'd0);
        end
    end

    // State registers. Reset takes priority and drops any operation in
    // flight, so an aborted multiply never produces a write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            count_q  <= 5'd0;
            rd_q     <= 4'd0;
            setf_q   <= 1'b0;
            result_q <= 32'd0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            setf_q   <= setf_d;
            result_q <= result_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    // stall_pc drops in DONE so the PC advances alongside the write-back.
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign write_en    = done;
    assign stall_pc    = ((state_q == ST_IDLE) && start) || (state_q == ST_RUN);
    assign flag_valid  = done && setf_q;
    assign rd_addr_out = rd_q;
    assign result      = result_q;
    assign flag_n      = flag_n_q;
    assign flag_z      = flag_z_q;

endmodule
